// File: rtl/bus_pkg.sv
// Shared definitions for the bus write side: destination codes, bus width
// and the memory-write FSM state encoding.
package bus_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [2:0] {
    DST_NONE = 3'd0,
    DST_R    = 3'd1,
    DST_DR   = 3'd2,
    DST_TR   = 3'd3,
    DST_PC   = 3'd4,
    DST_AC   = 3'd5,
    DST_AR   = 3'd6,
    DST_DM   = 3'd7
  } dst_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    ABORT   = 2'd2
  } dm_state_e;

endpackage

// File: rtl/dm_write_fsm.sv
// Data-memory write handshake: holds dm_we until ack or timeout, then returns
// to IDLE (via a one-cycle ABORT with dm_err on timeout).
//
// state   | meaning
// IDLE    | accepting bus writes, wr_ready high
// MEM_REQ | dm_we held, waiting for dm_ack, timeout counting down
// ABORT   | timeout hit, dm_err pulses for one cycle
module dm_write_fsm
  import bus_pkg::*;
#(
  parameter int DM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  input  logic       dm_ack_i,
  output logic       wr_ready_o,
  output logic       dm_we_o,
  output logic [7:0] dm_addr_o,
  output logic [7:0] dm_wdata_o,
  output logic       dm_err_o
);

  localparam logic [7:0] TMO_LOAD = 8'(DM_TIMEOUT - 1);

  dm_state_e  state_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ready_o <= 1'b1;
      dm_we_o    <= 1'b0;
      dm_addr_o  <= '0;
      dm_wdata_o <= '0;
      dm_err_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= MEM_REQ;
            cnt_q      <= TMO_LOAD;
            wr_ready_o <= 1'b0;
            dm_we_o    <= 1'b1;
            dm_addr_o  <= addr_i;
            dm_wdata_o <= data_i;
          end
        end
        MEM_REQ: begin
          // ack is checked first so a coincident ack beats the timeout
          if (dm_ack_i) begin
            state_q    <= IDLE;
            dm_we_o    <= 1'b0;
            wr_ready_o <= 1'b1;
          end else if (cnt_q == 8'd0) begin
            state_q  <= ABORT;
            dm_we_o  <= 1'b0;
            dm_err_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ABORT: begin
          state_q    <= IDLE;
          dm_err_o   <= 1'b0;
          wr_ready_o <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          dm_we_o    <= 1'b0;
          dm_err_o   <= 1'b0;
          wr_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_writer.sv
// Write end of the processor bus: register bank loads, micro-ops and the
// data-memory write handshake. BUS_WRITER_ZFLAG_EN adds the registered z flag.
module bus_writer
  import bus_pkg::*;
#(
  parameter int DM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] busin,
  input  logic [2:0]       write_en,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             r_inc,
  input  logic             pc_inc,
  input  logic             ac_inc,
  input  logic             ac_clr,
  output logic [7:0]       r,
  output logic [7:0]       dr,
  output logic [15:0]      tr,
  output logic [7:0]       pc,
  output logic [15:0]      ac,
  output logic [7:0]       ar,
  output logic             dm_we,
  output logic [7:0]       dm_addr,
  output logic [7:0]       dm_wdata,
  input  logic             dm_ack,
  output logic             dm_err
`ifdef BUS_WRITER_ZFLAG_EN
  ,
  output logic             z
`endif
);

  logic [7:0]  r_q, r_d, dr_q, dr_d, pc_q, pc_d, ar_q, ar_d;
  logic [15:0] tr_q, tr_d, ac_q, ac_d;
  logic        xfer;

  assign xfer = wr_valid && wr_ready;

  // per-register priority: bus write, then clear, then increment
  always_comb begin
    r_d  = r_q;
    dr_d = dr_q;
    tr_d = tr_q;
    pc_d = pc_q;
    ac_d = ac_q;
    ar_d = ar_q;
    if (xfer && write_en == DST_R)       r_d = busin[7:0];
    else if (r_inc)                      r_d = r_q + 8'd1;
    if (xfer && write_en == DST_DR)      dr_d = busin[7:0];
    if (xfer && write_en == DST_TR)      tr_d = busin;
    if (xfer && write_en == DST_PC)      pc_d = busin[7:0];
    else if (pc_inc)                     pc_d = pc_q + 8'd1;
    if (xfer && write_en == DST_AC)      ac_d = busin;
    else if (ac_clr)                     ac_d = '0;
    else if (ac_inc)                     ac_d = ac_q + 16'd1;
    if (xfer && write_en == DST_AR)      ar_d = busin[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      dr_q <= '0;
      tr_q <= '0;
      pc_q <= '0;
      ac_q <= '0;
      ar_q <= '0;
    end else begin
      r_q  <= r_d;
      dr_q <= dr_d;
      tr_q <= tr_d;
      pc_q <= pc_d;
      ac_q <= ac_d;
      ar_q <= ar_d;
    end
  end

  assign r  = r_q;
  assign dr = dr_q;
  assign tr = tr_q;
  assign pc = pc_q;
  assign ac = ac_q;
  assign ar = ar_q;

`ifdef BUS_WRITER_ZFLAG_EN
  logic z_q;
  logic ac_evt;

  assign ac_evt = (xfer && write_en == DST_AC) || ac_clr || ac_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         z_q <= 1'b0;
    else if (ac_evt) z_q <= (ac_d == 16'd0);
  end

  assign z = z_q;
`endif

  dm_write_fsm #(
    .DM_TIMEOUT(DM_TIMEOUT)
  ) u_dm_fsm (
    .clk        (clk),
    .rst        (rst),
    .start_i    (xfer && write_en == DST_DM),
    .addr_i     (ar_q),
    .data_i     (busin[7:0]),
    .dm_ack_i   (dm_ack),
    .wr_ready_o (wr_ready),
    .dm_we_o    (dm_we),
    .dm_addr_o  (dm_addr),
    .dm_wdata_o (dm_wdata),
    .dm_err_o   (dm_err)
  );

endmodule

// File: tb/tb_bus_writer.sv
// Self-checking bench for bus_writer: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the bus rules.
module tb_bus_writer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] busin;
  logic [2:0]  write_en;
  logic        wr_valid, wr_ready;
  logic        r_inc, pc_inc, ac_inc, ac_clr;
  logic [7:0]  r, dr, pc, ar, dm_addr, dm_wdata;
  logic [15:0] tr, ac;
  logic        dm_we, dm_ack, dm_err;
`ifdef BUS_WRITER_ZFLAG_EN
  logic        z;
`endif

  bus_writer #(.DM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .busin(busin), .write_en(write_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .r_inc(r_inc), .pc_inc(pc_inc), .ac_inc(ac_inc), .ac_clr(ac_clr),
    .r(r), .dr(dr), .tr(tr), .pc(pc), .ac(ac), .ar(ar),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_err(dm_err)
`ifdef BUS_WRITER_ZFLAG_EN
    , .z(z)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  m_r, m_dr, m_pc, m_ar, m_addr, m_wdata;
  logic [15:0] m_tr, m_ac;
  bit          m_we, m_err, m_z;
  int          m_high;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_r = 0; m_dr = 0; m_pc = 0; m_ar = 0; m_addr = 0; m_wdata = 0;
    m_tr = 0; m_ac = 0; m_we = 0; m_err = 0; m_z = 0; m_high = 0;
  endtask

  // one clock edge of the bus rules, using the inputs currently driven
  task automatic model_step();
    bit acc;
    bit ac_evt;
    acc = wr_valid && !m_we && !m_err;
    if (m_err) m_err = 0;
    else if (m_we) begin
      if (dm_ack) m_we = 0;
      else if (m_high == TO) begin m_we = 0; m_err = 1; end
      else m_high++;
    end else if (acc && write_en == 3'd7) begin
      m_we = 1; m_high = 1; m_addr = m_ar; m_wdata = busin[7:0];
    end
    if (acc && write_en == 3'd1) m_r = busin[7:0];
    else if (r_inc) m_r = m_r + 8'd1;
    if (acc && write_en == 3'd2) m_dr = busin[7:0];
    if (acc && write_en == 3'd3) m_tr = busin;
    if (acc && write_en == 3'd4) m_pc = busin[7:0];
    else if (pc_inc) m_pc = m_pc + 8'd1;
    ac_evt = 1;
    if (acc && write_en == 3'd5) m_ac = busin;
    else if (ac_clr) m_ac = 16'd0;
    else if (ac_inc) m_ac = m_ac + 16'd1;
    else ac_evt = 0;
    if (ac_evt) m_z = (m_ac == 16'd0);
    if (acc && write_en == 3'd6) m_ar = busin[7:0];
  endtask

  task automatic check_all();
    check("r", r, m_r);
    check("dr", dr, m_dr);
    check("tr", tr, m_tr);
    check("pc", pc, m_pc);
    check("ac", ac, m_ac);
    check("ar", ar, m_ar);
    check("dm_we", dm_we, m_we);
    check("dm_err", dm_err, m_err);
    check("wr_ready", wr_ready, !m_we && !m_err);
    if (m_we) begin
      check("dm_addr", dm_addr, m_addr);
      check("dm_wdata", dm_wdata, m_wdata);
    end
`ifdef BUS_WRITER_ZFLAG_EN
    check("z", z, m_z);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_in();
    busin = 0; write_en = 0; wr_valid = 0;
    r_inc = 0; pc_inc = 0; ac_inc = 0; ac_clr = 0; dm_ack = 0;
  endtask

  task automatic wr(input logic [2:0] code, input logic [15:0] data);
    idle_in();
    write_en = code; busin = data; wr_valid = 1;
  endtask

  int n_we, n_err;

  initial begin
    idle_in();
    model_reset();
    rst = 1'b1;
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // register loads
    wr(3'd1, 16'hABCD); step();
    check("r_load", r, 8'hCD);
    wr(3'd3, 16'h1234); step();
    check("tr_load", tr, 16'h1234);
    check("r_kept", r, 8'hCD);
    wr(3'd0, 16'hFFFF); step();

    // pc wrap and write-over-increment priority
    wr(3'd4, 16'h00FF); step();
    idle_in(); pc_inc = 1; step();
    check("pc_wrap", pc, 8'h00);
    wr(3'd4, 16'h0010); pc_inc = 1; step();
    check("pc_prio", pc, 8'h10);

    // memory write with ack, a held request waits for return to IDLE
    wr(3'd6, 16'h0042); step();
    wr(3'd7, 16'h00A5); step();
    check("dm_we_set", dm_we, 1'b1);
    check("dm_addr_cap", dm_addr, 8'h42);
    check("dm_wdata_cap", dm_wdata, 8'hA5);
    check("ready_low", wr_ready, 1'b0);
    wr(3'd1, 16'h0077); step(); step();
    dm_ack = 1; step();
    check("ack_we_drop", dm_we, 1'b0);
    check("ack_ready", wr_ready, 1'b1);
    check("held_not_yet", r, 8'hCD);
    dm_ack = 0; step();
    check("held_taken", r, 8'h77);

    // timeout abort
    wr(3'd7, 16'h0055); step();
    idle_in();
    n_we = dm_we ? 1 : 0; n_err = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dm_we) n_we++;
      if (dm_err) n_err++;
      if (wr_ready) break;
    end
    check("tmo_we_cycles", n_we, TO);
    check("tmo_err_pulses", n_err, 1);
    check("tmo_back_idle", wr_ready, 1'b1);

    // ack on the last timeout cycle wins
    wr(3'd7, 16'h0066); step();
    idle_in();
    for (int i = 0; i < TO - 1; i++) step();
    dm_ack = 1; step();
    check("coinc_no_err", dm_err, 1'b0);
    check("coinc_ready", wr_ready, 1'b1);
    idle_in(); step();
    check("coinc_no_err2", dm_err, 1'b0);

    // async reset between edges during MEM_REQ
    wr(3'd7, 16'h0011); step();
    idle_in(); step();
    #2 rst = 1'b1;
    #1;
    check("rst_we", dm_we, 1'b0);
    check("rst_r", r, 8'h00);
    check("rst_pc", pc, 8'h00);
    check("rst_tr", tr, 16'h0000);
    check("rst_ar", ar, 8'h00);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rst_no_reissue", dm_we, 1'b0);
    check("rst_ready", wr_ready, 1'b1);

    // ac wrap, clear priority and zero flag
    wr(3'd5, 16'hFFFF); step();
    idle_in(); ac_inc = 1; step();
    check("ac_wrap", ac, 16'h0000);
`ifdef BUS_WRITER_ZFLAG_EN
    check("z_set", z, 1'b1);
`endif
    wr(3'd5, 16'h0003); step();
`ifdef BUS_WRITER_ZFLAG_EN
    check("z_clr", z, 1'b0);
`endif
    idle_in(); ac_clr = 1; ac_inc = 1; step();
    check("ac_clr_prio", ac, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle_in();
      wr_valid = ($urandom_range(0, 1) == 1);
      write_en = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: busin = 16'hFFFF;
        1: busin = 16'h00FF;
        2: busin = 16'h0000;
        default: busin = 16'($urandom);
      endcase
      r_inc  = ($urandom_range(0, 3) == 0);
      pc_inc = ($urandom_range(0, 3) == 0);
      ac_inc = ($urandom_range(0, 3) == 0);
      ac_clr = ($urandom_range(0, 9) == 0);
      dm_ack = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
